decode_issue_unit: RTL
======================

Name: decode_issue_unit

Overview:
- Parametrised successor to the single-instruction decoder: buffers fetched RV32I instructions in a FIFO, decodes the head, looks up rename state and allocates a RoB entry.
- Issues one decoded packet per cycle to the reservation station (RS) or the load/store buffer (LSB).
- Adds back-pressure, flush, immediate generation and CDB snooping.
- Sits between the Fetcher and the RS/LSB/RoB/register file.

Parameters:
- IQ_DEPTH, 4, instruction queue entries; power of 2, at least 2.
- ROB_W, `ROB_SIZE_WIDTH, RoB index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- rdy  in  1  global enable; when 0, all state holds and outputs keep their values.
- flush  in  1  branch mispredict; empties the pipeline.
- if_valid  in  1  fetch offers an instruction.
- if_instr  in  32  instruction word.
- if_pc  in  32  instruction address.
- if_ready  out  1  queue can accept; equals count != IQ_DEPTH.
- rs1_idx, rs2_idx  out  5  rename lookup indices, combinational from queue head.
- rs1_val, rs2_val  in  32  register or forwarded RoB value.
- rs1_busy, rs2_busy  in  1  operand pending.
- rs1_rob, rs2_rob  in  ROB_W  producer RoB id.
- rob_full  in  1  RoB cannot allocate.
- rob_tail  in  ROB_W  id the next allocation receives.
- rs_full, lsb_full  in  1  target cannot accept.
- rob_alloc  out  1  dequeue/allocate strobe; RoB and register file update rename state on this edge.
- alloc_rd  out  5  destination register for the rename update.
- cdb_valid  in  1  common data bus broadcast.
- cdb_rob  in  ROB_W  broadcasting RoB id.
- cdb_val  in  32  broadcast value.
- iss_valid  out  1  one-cycle issue pulse.
- iss_to_lsb  out  1  1 = load/store, 0 = RS.
- iss_instr  out  32  instruction word.
- iss_pc  out  32  instruction address.
- iss_imm  out  32  sign-extended immediate.
- iss_v1, iss_v2  out  32  operand values.
- iss_q1_busy, iss_q2_busy  out  1  operand still pending.
- iss_q1, iss_q2  out  ROB_W  pending producer RoB id.
- iss_rd_rob  out  ROB_W  allocated RoB id.
- iss_rd  out  5  destination register.

Behaviour:
- Reset (rst=0, asynchronous): queue empty, head=tail=count=0, every iss_* output 0.
- Enqueue: on a clock edge when rdy && if_valid && if_ready && !flush. No enqueue at full even if a dequeue happens in the same cycle.
- Decode class from opcode[6:0]:
  - LUI, AUIPC, JAL: use neither rs1 nor rs2.
  - OP-IMM, LOAD, JALR: use rs1 only.
  - OP, BRANCH, STORE: use rs1 and rs2.
  - LOAD, STORE: target LSB. All other classes: target RS.
- Dequeue condition (cycle T, combinational): rdy && count>0 && !flush && !rob_full && !(target full). This asserts rob_alloc, with alloc_rd = rd for LUI/AUIPC/JAL/JALR/OP/OP-IMM/LOAD, else 0.
- Issue timing: iss_* registered at edge T+1, so latency is 1 cycle after dequeue. iss_valid is high exactly one cycle per dequeue. iss_rd_rob = rob_tail sampled at T.
- Operand capture:
  - Unused register or index x0: value 0, busy 0, q 0.
  - Otherwise take rs*_val/busy/rob at T.
  - If busy && cdb_valid && cdb_rob == rs*_rob at T: capture cdb_val, busy=0.
- Unknown opcode: dequeued without rob_alloc and without issue (dropped).
- iss_imm formats:
  - I-type: LOAD, JALR, OP-IMM; for shifts, imm = shamt, zero-extended.
  - S, B, U and J types: standard RV32I immediates.
  - OP: imm = 0.
- Flush has priority over enqueue and dequeue. The queue empties at the edge and iss_valid is 0 on the next cycle; a flush arriving while iss_valid=1 does not retract that pulse.
- Pointer wrap: modulo IQ_DEPTH. count is $clog2(IQ_DEPTH)+1 bits wide.
- Simultaneous enqueue and dequeue: count unchanged.
- Reset mid-operation discards all entries and pending issues.

Decomposition:
- Shared defines file (existing): ROB_SIZE_WIDTH, the RV32I opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP), and the decode class encoding.
- One combinational sub-module, decode_imm_gen (instruction in, 32-bit imm out). The FIFO and issue register stay in this block.

Test Plan:
- Reset with rst=0 mid-stream, then release: count=0, if_ready=1, iss_valid=0, all iss_* = 0.
- Fill 4 instructions with rs_full=1: if_ready=0 after the fourth enqueue; a fifth if_valid is not accepted; release rs_full -> 4 consecutive iss_valid pulses in order, PCs 0x0, 0x4, 0x8, 0xC.
- Instruction 0x00A00093 (addi x1,x0,10) with rob_tail=3 -> iss_imm=10, iss_v1=0, iss_q1_busy=0, iss_rd=1, iss_rd_rob=3, iss_to_lsb=0.
- Instruction sw x2,-4(x1) with rs1_busy=1, rs1_rob=5, and a same-cycle CDB broadcast (rob 5, value 0x100) -> iss_to_lsb=1, iss_v1=0x100, iss_q1_busy=0, iss_imm=0xFFFFFFFC, alloc_rd=0.
- Queue holding 3 entries, flush=1 with simultaneous if_valid=1 -> count=0 next cycle, no issue, the offered instruction is not enqueued.
- rob_full=1 for 3 cycles with a ready head -> no rob_alloc and no iss_valid during the stall; issue on the cycle after rob_full drops.

Source files
------------

// File: rtl/decode_issue_unit_pkg.sv
// Shared decode definitions for the decode/issue stage.
// Holds RV32I opcodes, the decode class encoding and the queue entry type.
package decode_issue_unit_pkg;

    localparam int ROB_SIZE_WIDTH = 4;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_RS1,
        CLS_RS12,
        CLS_BAD
    } dec_cls_e;

    typedef struct packed {
        logic     known;
        dec_cls_e cls;
        logic     to_lsb;
        logic     wr_rd;
    } dec_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } iq_entry_t;

    function automatic dec_t decode_op(input logic [6:0] opc);
        dec_t d;
        d.known  = 1'b1;
        d.cls    = CLS_NONE;
        d.to_lsb = 1'b0;
        d.wr_rd  = 1'b1;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL: d.cls = CLS_NONE;
            OPC_JALR, OPC_OP_IMM:        d.cls = CLS_RS1;
            OPC_OP:                      d.cls = CLS_RS12;
            OPC_LOAD: begin
                d.cls    = CLS_RS1;
                d.to_lsb = 1'b1;
            end
            OPC_STORE: begin
                d.cls    = CLS_RS12;
                d.to_lsb = 1'b1;
                d.wr_rd  = 1'b0;
            end
            OPC_BRANCH: begin
                d.cls   = CLS_RS12;
                d.wr_rd = 1'b0;
            end
            default: begin
                d.known = 1'b0;
                d.cls   = CLS_BAD;
                d.wr_rd = 1'b0;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// RV32I immediate generator (combinational).
// Ports: instr (32-bit word) in, imm (sign-extended immediate) out.
module decode_imm_gen
    import decode_issue_unit_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    logic [6:0] opc;
    logic [2:0] f3;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];

    always_comb begin
        imm = '0;
        case (opc)
            OPC_LUI, OPC_AUIPC:
                imm = {instr[31:12], 12'h000};
            OPC_JAL:
                imm = {{12{instr[31]}}, instr[19:12],
                       instr[20], instr[30:21], 1'b0};
            OPC_JALR, OPC_LOAD:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPC_OP_IMM: begin
                // shifts carry shamt in imm[4:0]; funct7 bits are not immediate
                if (f3 == 3'b001 || f3 == 3'b101)
                    imm = {27'h0, instr[24:20]};
                else
                    imm = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm = {{20{instr[31]}}, instr[7], instr[30:25],
                       instr[11:8], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_issue_unit.sv
// Decode/issue stage: instruction FIFO, head decode, rename lookup, RoB alloc.
// Ports: fetch handshake in, rename/RoB/CDB in, one registered issue packet out.
module decode_issue_unit
    import decode_issue_unit_pkg::*;
#(
    parameter int IQ_DEPTH = 4,
    parameter int ROB_W    = ROB_SIZE_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             if_valid,
    input  logic [31:0]      if_instr,
    input  logic [31:0]      if_pc,
    output logic             if_ready,
    output logic [4:0]       rs1_idx,
    output logic [4:0]       rs2_idx,
    input  logic [31:0]      rs1_val,
    input  logic [31:0]      rs2_val,
    input  logic             rs1_busy,
    input  logic             rs2_busy,
    input  logic [ROB_W-1:0] rs1_rob,
    input  logic [ROB_W-1:0] rs2_rob,
    input  logic             rob_full,
    input  logic [ROB_W-1:0] rob_tail,
    input  logic             rs_full,
    input  logic             lsb_full,
    output logic             rob_alloc,
    output logic [4:0]       alloc_rd,
    input  logic             cdb_valid,
    input  logic [ROB_W-1:0] cdb_rob,
    input  logic [31:0]      cdb_val,
    output logic             iss_valid,
    output logic             iss_to_lsb,
    output logic [31:0]      iss_instr,
    output logic [31:0]      iss_pc,
    output logic [31:0]      iss_imm,
    output logic [31:0]      iss_v1,
    output logic [31:0]      iss_v2,
    output logic             iss_q1_busy,
    output logic             iss_q2_busy,
    output logic [ROB_W-1:0] iss_q1,
    output logic [ROB_W-1:0] iss_q2,
    output logic [ROB_W-1:0] iss_rd_rob,
    output logic [4:0]       iss_rd
);

    localparam int PW = $clog2(IQ_DEPTH);
    localparam int CW = PW + 1;

    iq_entry_t       iq [IQ_DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;

    iq_entry_t       hd;
    dec_t            dec;
    logic            use1;
    logic            use2;
    logic            tgt_full;
    logic            deq;
    logic            enq;
    logic [31:0]     imm;

    logic [31:0]     v1;
    logic [31:0]     v2;
    logic            b1;
    logic            b2;
    logic [ROB_W-1:0] q1;
    logic [ROB_W-1:0] q2;

    assign hd   = iq[head];
    assign dec  = decode_op(hd.instr[6:0]);
    assign use1 = (dec.cls == CLS_RS1) || (dec.cls == CLS_RS12);
    assign use2 = (dec.cls == CLS_RS12);

    assign tgt_full = dec.to_lsb ? lsb_full : rs_full;
    assign if_ready = (count != CW'(IQ_DEPTH));
    assign enq      = rdy && if_valid && if_ready && !flush;

    // unknown opcodes are dropped without waiting on any resource
    assign deq = rdy && (count != '0) && !flush &&
                 (!dec.known || (!rob_full && !tgt_full));

    assign rob_alloc = deq && dec.known;
    assign rs1_idx   = hd.instr[19:15];
    assign rs2_idx   = hd.instr[24:20];
    assign alloc_rd  = dec.wr_rd ? hd.instr[11:7] : 5'd0;

    decode_imm_gen u_imm (
        .instr (hd.instr),
        .imm   (imm)
    );

    // a broadcast in the issue cycle resolves the operand on the spot
    always_comb begin
        v1 = '0;
        b1 = 1'b0;
        q1 = '0;
        if (use1 && rs1_idx != 5'd0) begin
            v1 = rs1_val;
            b1 = rs1_busy;
            q1 = rs1_rob;
            if (rs1_busy && cdb_valid && cdb_rob == rs1_rob) begin
                v1 = cdb_val;
                b1 = 1'b0;
            end
        end
    end

    always_comb begin
        v2 = '0;
        b2 = 1'b0;
        q2 = '0;
        if (use2 && rs2_idx != 5'd0) begin
            v2 = rs2_val;
            b2 = rs2_busy;
            q2 = rs2_rob;
            if (rs2_busy && cdb_valid && cdb_rob == rs2_rob) begin
                v2 = cdb_val;
                b2 = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq)
            iq[tail] <= '{instr: if_instr, pc: if_pc};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (enq)
                    tail <= tail + 1'b1;
                if (deq)
                    head <= head + 1'b1;
                case ({enq, deq})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_valid   <= 1'b0;
            iss_to_lsb  <= 1'b0;
            iss_instr   <= '0;
            iss_pc      <= '0;
            iss_imm     <= '0;
            iss_v1      <= '0;
            iss_v2      <= '0;
            iss_q1_busy <= 1'b0;
            iss_q2_busy <= 1'b0;
            iss_q1      <= '0;
            iss_q2      <= '0;
            iss_rd_rob  <= '0;
            iss_rd      <= '0;
        end else if (rdy) begin
            iss_valid <= rob_alloc;
            if (rob_alloc) begin
                iss_to_lsb  <= dec.to_lsb;
                iss_instr   <= hd.instr;
                iss_pc      <= hd.pc;
                iss_imm     <= imm;
                iss_v1      <= v1;
                iss_v2      <= v2;
                iss_q1_busy <= b1;
                iss_q2_busy <= b2;
                iss_q1      <= q1;
                iss_q2      <= q2;
                iss_rd_rob  <= rob_tail;
                iss_rd      <= alloc_rd;
            end
        end
    end

endmodule
